// File: rtl/mem_pkg.sv
// Shared memory parameters and helpers.
// Used by the RAM-based blocks that size their storage from an address width.
package mem_pkg;

  localparam int DATA_W_DEF = 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Two-port RAM with one synchronous write port (A) and one registered read port (B).
// A read that hits the address being written in the same cycle returns the old word.
module dp_ram_core
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // The array is deliberately left without a reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr_a] <= din;
    if (re) dout <= mem_q[addr_b];
  end

endmodule

// File: rtl/dp_ram_fifo.sv
// Synchronous FIFO around dp_ram_core: pointers, registered count and flags,
// and one-cycle overflow/underflow pulses.
module dp_ram_fifo
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              rd_valid_q;
  logic              rd_seen_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_accept;
  logic              wr_accept;
  logic [DATA_W-1:0] ram_dout;

  assign rd_accept = rd_en && !empty_q;
  assign wr_accept = wr_en && (!full_q || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_accept && !rd_accept) count_d = count_q + 1'b1;
    if (rd_accept && !wr_accept) count_d = count_q - 1'b1;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
              (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_accept;
      overflow_q  <= wr_en && !wr_accept;
      underflow_q <= rd_en && empty_q;
      if (rd_accept) rd_seen_q <= 1'b1;
    end
  end

  dp_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .addr_a(wr_ptr_q[ADDR_W-1:0]),
    .din   (wr_data),
    .re    (rd_accept),
    .addr_b(rd_ptr_q[ADDR_W-1:0]),
    .dout  (ram_dout)
  );

  // The RAM output register has no reset; mask it until a read has happened
  // since reset so rd_data starts at zero and otherwise holds the last word.
  assign rd_data   = rd_seen_q ? ram_dout : '0;
  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_dp_ram_fifo.sv
// Randomised and directed bench for dp_ram_fifo against a queue-based reference model.
module tb_dp_ram_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_err = 0;
  logic [7:0] mdl_q[$];
  logic [7:0] last_rd = '0;

  always #5 clk = ~clk;

  dp_ram_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic; the model decides acceptance from the FIFO occupancy.
  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    int  sz;
    bit  ra, wa;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    sz = mdl_q.size();
    ra = re && (sz != 0);
    wa = we && ((sz < 8) || ra);
    @(posedge clk);
    #1;
    if (ra) last_rd = mdl_q.pop_front();
    if (wa) mdl_q.push_back(wd);
    chk("count", 32'(count), 32'(mdl_q.size()));
    chk("full", 32'(full), 32'(mdl_q.size() == 8));
    chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
    chk("rd_valid", 32'(rd_valid), 32'(ra));
    chk("rd_data", 32'(rd_data), 32'(last_rd));
    chk("overflow", 32'(overflow), 32'(we && !wa));
    chk("underflow", 32'(underflow), 32'(re && (sz == 0)));
    $display("cyc we=%0b wd=%02h re=%0b -> cnt=%0d vld=%0b rd=%02h", we, wd, re, count, rd_valid, rd_data);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("idle");

    // Fill with i*8+32, then drain in order.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i * 8 + 32), 1'b0);
    chk("filled_full", 32'(full), 32'd1);
    chk("filled_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_last", 32'(rd_data), 32'h58);

    // Overflow when full; the rejected word must never come out.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    // Underflow when empty, then simultaneous read+write while empty.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("bypass_11", 32'(rd_data), 32'h11);

    // Simultaneous read+write while full.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("last_aa", 32'(rd_data), 32'hAA);

    // Random interleaved traffic across many pointer wraps.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset mid-stream with a read result on the outputs.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    rd_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    rd_en = 1'b0;
    mdl_q.delete();
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
